// File: rtl/csr_unit.sv
// Machine-mode CSR file for a pipelined RV32 core: CSR read/write, a 64-bit cycle
// counter, and interrupt entry/mret redirects handled by a two-state RUN/HOLD FSM.
module csr_unit #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        csr_reg_r,
   input  logic        csr_reg_wr,
   input  logic        is_mret,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   input  logic [31:0] pc,
   input  logic        timer_irq,
   input  logic        ext_irq,
   output logic [31:0] csr_rdata,
   output logic        epc_taken,
   output logic [31:0] epc
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MIE     = 12'h304;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MIP     = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;

   localparam logic [3:0] CAUSE_TIMER = 4'd7;
   localparam logic [3:0] CAUSE_EXT   = 4'd11;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t      state;

   logic        status_mie;
   logic        status_mpie;
   logic        mie_mtie;
   logic        mie_meie;
   logic [31:0] mtvec;
   logic [31:2] mepc_hi;
   logic [31:0] mcause;
   logic [63:0] mcycle;

   logic        wr_en;
   logic        ext_pend;
   logic        timer_pend;
   logic        pending;
   logic        trap_take;
   logic        mret_take;
   logic [3:0]  trap_cause;
   logic [31:0] trap_target;
   logic [31:0] mstatus_val;
   logic [31:0] mie_val;
   logic [31:0] mip_val;
   logic [31:0] mepc_val;

   assign mstatus_val = {24'b0, status_mpie, 3'b0, status_mie, 3'b0};
   assign mie_val     = {20'b0, mie_meie, 3'b0, mie_mtie, 7'b0};
   assign mip_val     = {20'b0, ext_irq, 3'b0, timer_irq, 7'b0};
   assign mepc_val    = {mepc_hi, 2'b00};

   // Trap/mret decisions; reset suppresses both so nothing redirects while rst is high.
   always_comb begin
      wr_en      = csr_reg_wr & ~stall;
      ext_pend   = status_mie & mie_meie & ext_irq;
      timer_pend = status_mie & mie_mtie & timer_irq;
      pending    = ext_pend | timer_pend;
      trap_take  = ~rst & (state == RUN) & pending & ~stall & ~csr_reg_wr & ~is_mret;
      mret_take  = ~rst & (state == RUN) & is_mret & ~stall;
      trap_cause = ext_pend ? CAUSE_EXT : CAUSE_TIMER;
   end

   // Vectored mode only for mtvec[1:0]==01; the reserved 1x encodings fall back to direct.
   always_comb begin
      trap_target = {mtvec[31:2], 2'b00};
      if (mtvec[1:0] == 2'b01) begin
         trap_target = {mtvec[31:2], 2'b00} + {26'b0, trap_cause, 2'b00};
      end
   end

   always_comb begin
      epc_taken = trap_take | mret_take;
      epc       = 32'h0;
      if (trap_take) begin
         epc = trap_target;
      end else if (mret_take) begin
         epc = mepc_val;
      end
   end

   always_comb begin
      csr_rdata = 32'h0;
      if (csr_reg_r) begin
         case (csr_addr)
            ADDR_MSTATUS: csr_rdata = mstatus_val;
            ADDR_MIE:     csr_rdata = mie_val;
            ADDR_MTVEC:   csr_rdata = mtvec;
            ADDR_MEPC:    csr_rdata = mepc_val;
            ADDR_MCAUSE:  csr_rdata = mcause;
            ADDR_MIP:     csr_rdata = mip_val;
            ADDR_MCYCLE:  csr_rdata = mcycle[31:0];
            ADDR_MCYCLEH: csr_rdata = mcycle[63:32];
            default:      csr_rdata = 32'h0;
         endcase
      end
   end

   // Software writes first; trap and mret entry follow so they win on shared mstatus bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         status_mie  <= 1'b0;
         status_mpie <= 1'b0;
         mie_mtie    <= 1'b0;
         mie_meie    <= 1'b0;
         mtvec       <= MTVEC_RESET;
         mepc_hi     <= 30'h0;
         mcause      <= 32'h0;
         mcycle      <= 64'h0;
      end else begin
         if (wr_en && csr_addr == ADDR_MCYCLE) begin
            mcycle[31:0] <= csr_wdata;
         end else if (wr_en && csr_addr == ADDR_MCYCLEH) begin
            mcycle[63:32] <= csr_wdata;
         end else begin
            mcycle <= mcycle + 64'd1;
         end

         if (wr_en) begin
            case (csr_addr)
               ADDR_MSTATUS: begin
                  status_mie  <= csr_wdata[3];
                  status_mpie <= csr_wdata[7];
               end
               ADDR_MIE: begin
                  mie_mtie <= csr_wdata[7];
                  mie_meie <= csr_wdata[11];
               end
               ADDR_MTVEC:  mtvec   <= csr_wdata;
               ADDR_MEPC:   mepc_hi <= csr_wdata[31:2];
               ADDR_MCAUSE: mcause  <= csr_wdata;
               default: ;
            endcase
         end

         if (trap_take) begin
            mepc_hi     <= pc[31:2];
            mcause      <= {1'b1, 27'b0, trap_cause};
            status_mpie <= status_mie;
            status_mie  <= 1'b0;
         end else if (mret_take) begin
            status_mie  <= status_mpie;
            status_mpie <= 1'b1;
         end

         // HOLD covers exactly the one flushed bubble after any redirect.
         if (trap_take || mret_take) begin
            state <= HOLD;
         end else begin
            state <= RUN;
         end
      end
   end

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit: CSR access, counter wrap, trap entry,
// mret, deferral and reset override.
module tb_csr_unit;

   localparam logic [31:0] MTVEC_INIT = 32'h0000_1000;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        csr_reg_r;
   logic        csr_reg_wr;
   logic        is_mret;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] pc;
   logic        timer_irq;
   logic        ext_irq;
   logic [31:0] csr_rdata;
   logic        epc_taken;
   logic [31:0] epc;

   int pass_count = 0;
   int check_count = 0;
   logic [31:0] rd_val;

   csr_unit #(.MTVEC_RESET(MTVEC_INIT)) dut (
      .clk(clk), .rst(rst), .stall(stall), .csr_reg_r(csr_reg_r),
      .csr_reg_wr(csr_reg_wr), .is_mret(is_mret), .csr_addr(csr_addr),
      .csr_wdata(csr_wdata), .pc(pc), .timer_irq(timer_irq), .ext_irq(ext_irq),
      .csr_rdata(csr_rdata), .epc_taken(epc_taken), .epc(epc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_csr(input logic [11:0] addr, input logic [31:0] data);
      csr_reg_wr = 1'b1;
      csr_addr   = addr;
      csr_wdata  = data;
      tick();
      csr_reg_wr = 1'b0;
      csr_wdata  = 32'h0;
   endtask

   task automatic read_csr(input logic [11:0] addr, output logic [31:0] data);
      csr_reg_r = 1'b1;
      csr_addr  = addr;
      #1;
      data      = csr_rdata;
      csr_reg_r = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; is_mret = 1'b1;
      #1;
      check_count++;
      if (epc_taken !== 1'b0) $display("[TB] FAIL reset_no_redirect got=%0b exp=0", epc_taken); else pass_count++;
      tick();
      rst = 1'b0; is_mret = 1'b0;
      read_csr(12'h300, rd_val);
      check_count++;
      if (rd_val !== 32'h0) $display("[TB] FAIL reset_mstatus got=%h exp=%h", rd_val, 32'h0); else pass_count++;
      read_csr(12'h305, rd_val);
      check_count++;
      if (rd_val !== MTVEC_INIT) $display("[TB] FAIL reset_mtvec got=%h exp=%h", rd_val, MTVEC_INIT); else pass_count++;
      read_csr(12'hB00, rd_val);
      check_count++;
      if (rd_val !== 32'h0) $display("[TB] FAIL reset_mcycle got=%h exp=%h", rd_val, 32'h0); else pass_count++;
   endtask

   task automatic test_write_read();
      csr_reg_r = 1'b1; csr_reg_wr = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h0000_0101;
      #1;
      check_count++;
      if (csr_rdata !== MTVEC_INIT) $display("[TB] FAIL wr_old_value got=%h exp=%h", csr_rdata, MTVEC_INIT); else pass_count++;
      tick();
      csr_reg_wr = 1'b0; csr_reg_r = 1'b0;
      read_csr(12'h305, rd_val);
      check_count++;
      if (rd_val !== 32'h0000_0101) $display("[TB] FAIL wr_new_value got=%h exp=%h", rd_val, 32'h101); else pass_count++;
      wr_csr(12'h7C0, 32'hDEAD_BEEF);
      read_csr(12'h7C0, rd_val);
      check_count++;
      if (rd_val !== 32'h0) $display("[TB] FAIL unimpl_read got=%h exp=%h", rd_val, 32'h0); else pass_count++;
      timer_irq = 1'b1; ext_irq = 1'b1;
      wr_csr(12'h344, 32'h0);
      read_csr(12'h344, rd_val);
      check_count++;
      if (rd_val !== 32'h0000_0880) $display("[TB] FAIL mip_readonly got=%h exp=%h", rd_val, 32'h880); else pass_count++;
      timer_irq = 1'b0; ext_irq = 1'b0;
      csr_addr = 12'h305;
      #1;
      check_count++;
      if (csr_rdata !== 32'h0) $display("[TB] FAIL read_gated got=%h exp=%h", csr_rdata, 32'h0); else pass_count++;
   endtask

   task automatic test_counter();
      wr_csr(12'hB00, 32'hFFFF_FFFF);
      wr_csr(12'hB80, 32'hFFFF_FFFF);
      read_csr(12'hB00, rd_val);
      check_count++;
      if (rd_val !== 32'hFFFF_FFFF) $display("[TB] FAIL mcycle_lo_hold got=%h exp=%h", rd_val, 32'hFFFF_FFFF); else pass_count++;
      read_csr(12'hB80, rd_val);
      check_count++;
      if (rd_val !== 32'hFFFF_FFFF) $display("[TB] FAIL mcycle_hi_set got=%h exp=%h", rd_val, 32'hFFFF_FFFF); else pass_count++;
      tick();
      read_csr(12'hB00, rd_val);
      check_count++;
      if (rd_val !== 32'h0) $display("[TB] FAIL mcycle_wrap_lo got=%h exp=%h", rd_val, 32'h0); else pass_count++;
      read_csr(12'hB80, rd_val);
      check_count++;
      if (rd_val !== 32'h0) $display("[TB] FAIL mcycle_wrap_hi got=%h exp=%h", rd_val, 32'h0); else pass_count++;
      tick();
      read_csr(12'hB00, rd_val);
      check_count++;
      if (rd_val !== 32'h1) $display("[TB] FAIL mcycle_inc got=%h exp=%h", rd_val, 32'h1); else pass_count++;
   endtask

   task automatic test_direct_trap();
      wr_csr(12'h305, 32'h0000_0100);
      wr_csr(12'h304, 32'h0000_0080);
      wr_csr(12'h300, 32'h0000_0008);
      timer_irq = 1'b1; pc = 32'h40;
      #1;
      check_count++;
      if (epc_taken !== 1'b1 || epc !== 32'h100) $display("[TB] FAIL direct_trap got=%0b/%h exp=1/%h", epc_taken, epc, 32'h100); else pass_count++;
      tick();
      is_mret = 1'b1;
      #1;
      check_count++;
      if (epc_taken !== 1'b0 || epc !== 32'h0) $display("[TB] FAIL hold_ignores got=%0b/%h exp=0/0", epc_taken, epc); else pass_count++;
      is_mret = 1'b0;
      read_csr(12'h341, rd_val);
      check_count++;
      if (rd_val !== 32'h40) $display("[TB] FAIL trap_mepc got=%h exp=%h", rd_val, 32'h40); else pass_count++;
      read_csr(12'h342, rd_val);
      check_count++;
      if (rd_val !== 32'h8000_0007) $display("[TB] FAIL trap_mcause got=%h exp=%h", rd_val, 32'h8000_0007); else pass_count++;
      read_csr(12'h300, rd_val);
      check_count++;
      if (rd_val !== 32'h80) $display("[TB] FAIL trap_mstatus got=%h exp=%h", rd_val, 32'h80); else pass_count++;
      tick();
      check_count++;
      if (epc_taken !== 1'b0) $display("[TB] FAIL no_second_trap got=%0b exp=0", epc_taken); else pass_count++;
      timer_irq = 1'b0;
   endtask

   task automatic test_mret();
      wr_csr(12'h341, 32'h0000_0047);
      read_csr(12'h341, rd_val);
      check_count++;
      if (rd_val !== 32'h44) $display("[TB] FAIL mepc_align got=%h exp=%h", rd_val, 32'h44); else pass_count++;
      stall = 1'b1; is_mret = 1'b1;
      #1;
      check_count++;
      if (epc_taken !== 1'b0) $display("[TB] FAIL mret_stalled got=%0b exp=0", epc_taken); else pass_count++;
      tick();
      stall = 1'b0; is_mret = 1'b0;
      read_csr(12'h300, rd_val);
      check_count++;
      if (rd_val !== 32'h80) $display("[TB] FAIL mret_stall_nochg got=%h exp=%h", rd_val, 32'h80); else pass_count++;
      timer_irq = 1'b1; is_mret = 1'b1;
      #1;
      check_count++;
      if (epc_taken !== 1'b1 || epc !== 32'h44) $display("[TB] FAIL mret_redirect got=%0b/%h exp=1/%h", epc_taken, epc, 32'h44); else pass_count++;
      tick();
      is_mret = 1'b0;
      #1;
      check_count++;
      if (epc_taken !== 1'b0) $display("[TB] FAIL mret_hold_no_trap got=%0b exp=0", epc_taken); else pass_count++;
      read_csr(12'h300, rd_val);
      check_count++;
      if (rd_val !== 32'h88) $display("[TB] FAIL mret_mstatus got=%h exp=%h", rd_val, 32'h88); else pass_count++;
      tick();
      check_count++;
      if (epc_taken !== 1'b1 || epc !== 32'h100) $display("[TB] FAIL post_mret_trap got=%0b/%h exp=1/%h", epc_taken, epc, 32'h100); else pass_count++;
      tick();
      timer_irq = 1'b0;
      tick();
   endtask

   task automatic test_vectored();
      wr_csr(12'h305, 32'h0000_0201);
      wr_csr(12'h304, 32'h0000_0880);
      wr_csr(12'h300, 32'h0000_0008);
      timer_irq = 1'b1; ext_irq = 1'b1; pc = 32'h50;
      #1;
      check_count++;
      if (epc_taken !== 1'b1 || epc !== 32'h22C) $display("[TB] FAIL vectored_ext got=%0b/%h exp=1/%h", epc_taken, epc, 32'h22C); else pass_count++;
      tick();
      read_csr(12'h342, rd_val);
      check_count++;
      if (rd_val !== 32'h8000_000B) $display("[TB] FAIL vectored_mcause got=%h exp=%h", rd_val, 32'h8000_000B); else pass_count++;
      timer_irq = 1'b0; ext_irq = 1'b0;
      tick();
   endtask

   task automatic test_deferral();
      timer_irq = 1'b1;
      csr_reg_wr = 1'b1; csr_addr = 12'h300; csr_wdata = 32'h0000_0008;
      #1;
      check_count++;
      if (epc_taken !== 1'b0) $display("[TB] FAIL enable_write_cycle got=%0b exp=0", epc_taken); else pass_count++;
      tick();
      csr_reg_wr = 1'b0;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_count++;
         if (epc_taken !== 1'b0) $display("[TB] FAIL defer_stall%0d got=%0b exp=0", i, epc_taken); else pass_count++;
         tick();
      end
      stall = 1'b0; csr_reg_wr = 1'b1; csr_addr = 12'h7C0;
      #1;
      check_count++;
      if (epc_taken !== 1'b0) $display("[TB] FAIL defer_write got=%0b exp=0", epc_taken); else pass_count++;
      tick();
      csr_reg_wr = 1'b0;
      #1;
      check_count++;
      if (epc_taken !== 1'b1 || epc !== 32'h21C) $display("[TB] FAIL defer_fire got=%0b/%h exp=1/%h", epc_taken, epc, 32'h21C); else pass_count++;
      tick();
      timer_irq = 1'b0;
      tick();
   endtask

   task automatic test_reset_override();
      wr_csr(12'h300, 32'h0000_0008);
      timer_irq = 1'b1; pc = 32'h60; rst = 1'b1;
      #1;
      check_count++;
      if (epc_taken !== 1'b0) $display("[TB] FAIL reset_vs_trap got=%0b exp=0", epc_taken); else pass_count++;
      tick();
      rst = 1'b0; timer_irq = 1'b0;
      read_csr(12'h341, rd_val);
      check_count++;
      if (rd_val !== 32'h0) $display("[TB] FAIL reset_trap_mepc got=%h exp=%h", rd_val, 32'h0); else pass_count++;
      wr_csr(12'h304, 32'h0000_0080);
      wr_csr(12'h300, 32'h0000_0008);
      timer_irq = 1'b1;
      tick();
      rst = 1'b1; is_mret = 1'b1; csr_reg_wr = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h0000_0ABC;
      tick();
      rst = 1'b0; is_mret = 1'b0; csr_reg_wr = 1'b0; timer_irq = 1'b0;
      read_csr(12'h305, rd_val);
      check_count++;
      if (rd_val !== MTVEC_INIT) $display("[TB] FAIL hold_rst_mtvec got=%h exp=%h", rd_val, MTVEC_INIT); else pass_count++;
      read_csr(12'h342, rd_val);
      check_count++;
      if (rd_val !== 32'h0) $display("[TB] FAIL hold_rst_mcause got=%h exp=%h", rd_val, 32'h0); else pass_count++;
      read_csr(12'h304, rd_val);
      check_count++;
      if (rd_val !== 32'h0) $display("[TB] FAIL hold_rst_mie got=%h exp=%h", rd_val, 32'h0); else pass_count++;
      read_csr(12'h300, rd_val);
      check_count++;
      if (rd_val !== 32'h0) $display("[TB] FAIL hold_rst_mstatus got=%h exp=%h", rd_val, 32'h0); else pass_count++;
      is_mret = 1'b1;
      #1;
      check_count++;
      if (epc_taken !== 1'b1 || epc !== 32'h0) $display("[TB] FAIL hold_rst_run got=%0b/%h exp=1/0", epc_taken, epc); else pass_count++;
      is_mret = 1'b0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; csr_reg_r = 1'b0; csr_reg_wr = 1'b0; is_mret = 1'b0;
      csr_addr = 12'h0; csr_wdata = 32'h0; pc = 32'h0; timer_irq = 1'b0; ext_irq = 1'b0;
      tick();
      tick();
      test_reset();
      test_write_read();
      test_counter();
      test_direct_trap();
      test_mret();
      test_vectored();
      test_deferral();
      test_reset_override();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 The parameter list SHALL contain: MTVEC_RESET, 32'h0000_0000, mtvec value after reset.
REQ-002 The port list SHALL contain: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 The port list SHALL contain: rst  in  1  reset, synchronous and active-high.
REQ-004 The port list SHALL contain: stall  in  1  pipeline stall; trap acceptance is blocked while high.
REQ-005 The port list SHALL contain: csr_reg_r  in  1  CSR read request (pipelined controller flag).
REQ-006 The port list SHALL contain: csr_reg_wr  in  1  CSR write request (csrrw).
REQ-007 The port list SHALL contain: is_mret  in  1  mret in this stage.
REQ-008 The port list SHALL contain: csr_addr  in  12  CSR address (instr[31:20]).
REQ-009 The port list SHALL contain: csr_wdata  in  32  rs1 value.
REQ-010 The port list SHALL contain: pc  in  32  PC of the instruction currently in this stage.
REQ-011 The port list SHALL contain: timer_irq  in  1  level-high timer interrupt.
REQ-012 The port list SHALL contain: ext_irq  in  1  level-high external interrupt.
REQ-013 The port list SHALL contain: csr_rdata  out  32  read data for write-back select 2'b11.
REQ-014 The port list SHALL contain: epc_taken  out  1  redirect: fetch loads epc and the pipeline flushes.
REQ-015 The port list SHALL contain: epc  out  32  redirect target.

Function
REQ-016 The implemented CSRs SHALL be mstatus 0x300 (MIE b3, MPIE b7, other bits read 0), mie 0x304 (MTIE b7, MEIE b11), mtvec 0x305, mepc 0x341 (b[1:0] always 0), mcause 0x342, mip 0x344 (read-only), mcycle 0xB00, and mcycleh 0xB80.
REQ-017 mip SHALL read MTIP b7 = timer_irq and MEIP b11 = ext_irq, and writes to mip SHALL be ignored.
REQ-018 csr_rdata SHALL be combinational: it is the current value at csr_addr when csr_reg_r=1, otherwise 0. An unimplemented address SHALL read 0.
REQ-019 A write SHALL occur when csr_reg_wr=1 and stall=0. The new value SHALL be visible at the next edge. csr_rdata in the write cycle SHALL return the old value. Writes to unimplemented addresses SHALL be ignored.
REQ-020 mcycle SHALL be a 64-bit counter incremented by 1 every non-reset cycle and wrapping from 2^64-1 to 0.
REQ-021 A write to 0xB00 or 0xB80 SHALL replace that half, and in that cycle the whole counter SHALL NOT increment.
REQ-022 The FSM SHALL have two states: RUN and HOLD.
REQ-023 An interrupt SHALL be pending when mstatus.MIE=1 and ((mie.MEIE & ext_irq) | (mie.MTIE & timer_irq)).
REQ-024 A trap SHALL be taken when state=RUN, pending=1, stall=0, csr_reg_wr=0 and is_mret=0; otherwise the interrupt SHALL be deferred, with no loss because the lines are level-sensitive.
REQ-025 Trap priority SHALL be external (cause 11) over timer (cause 7).
REQ-026 On trap: epc_taken=1 in the same cycle. If mtvec[1:0]=00, epc={mtvec[31:2],2'b00}. If mtvec[1:0]=01, epc={mtvec[31:2],2'b00}+4*cause. mtvec[1:0]=1x SHALL be treated as 00.
REQ-027 At the trap edge: mepc<=pc, mcause<={1'b1,27'b0,cause[3:0]}, MPIE<=MIE, MIE<=0, state<=HOLD.
REQ-028 On mret with stall=0: epc_taken=1 and epc=mepc in the same cycle.
REQ-029 At the mret edge: MIE<=MPIE, MPIE<=1, state<=HOLD.
REQ-030 mret while stall=1 SHALL produce no redirect and no state change.
REQ-031 HOLD SHALL last exactly one cycle (the flushed bubble), then return to RUN. In HOLD, epc_taken=0, no trap is taken, and mret is ignored.
REQ-032 epc_taken SHALL be 0 and epc SHALL be 0 in every cycle that takes no trap and no mret.
REQ-033 A csrrw to mstatus SHALL update MIE/MPIE at the edge. An interrupt enabled by that write SHALL be taken no earlier than the following cycle.

Reset
REQ-034 With rst=1 at an edge: mstatus=0, mie=0, mtvec=MTVEC_RESET, mepc=0, mcause=0, mcycle=0, state=RUN.
REQ-035 epc_taken SHALL be 0 in every cycle where rst=1.
REQ-036 Reset asserted mid-HOLD or concurrently with a trap/mret/write SHALL override everything, and no CSR update from that cycle SHALL be retained.

Verification
REQ-037 Write/read: csrrw 0x305 wdata=32'h0000_0101 -> rdata in the same cycle = old 0; the next read of 0x305 = 32'h0000_0101; a read of 0x7C0 = 0.
REQ-038 Direct trap: mtvec=32'h100, mie=32'h80, mstatus=32'h8, timer_irq=1, pc=32'h40 -> epc_taken=1, epc=32'h100; next cycle mepc=32'h40, mcause=32'h8000_0007, mstatus=32'h80, state HOLD; timer_irq still high gives no second trap.
REQ-039 Vectored with simultaneous irqs: mtvec=32'h201, mie=32'h880, both irqs high -> epc=32'h22C, mcause=32'h8000_000B.
REQ-040 mret: mepc=32'h44, mstatus=32'h80, is_mret=1 -> epc_taken=1, epc=32'h44; next mstatus=32'h88; pending irq taken no earlier than 2 cycles later.
REQ-041 Deferral: pending irq with stall=1 for 3 cycles, or with csr_reg_wr=1 -> no trap; trap fires on the first qualifying cycle.
REQ-042 Counter: write 0xB00=32'hFFFF_FFFF and 0xB80=32'hFFFF_FFFF -> after 1 free cycle mcycle=0 (wrap); rst mid-HOLD -> state RUN, all CSRs at reset values.
